// File: rtl/fpu_add_arbiter_if.sv
// ============================================================================
// Module  : fpu_add_arbiter_if
// Brief   : Requester bus and shared-adder stb/ack handshake for the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpu_add_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_z;
  logic                  busy;
  logic [31:0]           input_a;
  logic                  input_a_stb;
  logic                  input_a_ack;
  logic [31:0]           input_b;
  logic                  input_b_stb;
  logic                  input_b_ack;
  logic [31:0]           output_z;
  logic                  output_z_stb;
  logic                  output_z_ack;

  modport master (
    input  req, req_a, req_b, input_a_ack, input_b_ack, output_z, output_z_stb,
    output grant, rsp_valid, rsp_z, busy, input_a, input_a_stb, input_b,
           input_b_stb, output_z_ack
  );

  modport slave (
    output req, req_a, req_b, input_a_ack, input_b_ack, output_z, output_z_stb,
    input  grant, rsp_valid, rsp_z, busy, input_a, input_a_stb, input_b,
           input_b_stb, output_z_ack
  );
endinterface

`default_nettype wire

// File: rtl/fpu_add_arbiter.sv
// ============================================================================
// Module  : fpu_add_arbiter
// Brief   : Round-robin sharing of one stb/ack FP adder among NUM_REQ clients.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input wire clk,
  input wire rst,
  fpu_add_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_WAIT_Z = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0]   c_last = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]     c_num  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] c_one  = NUM_REQ'(1);

  state_t               r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_win;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [31:0]          r_rsp_z;
  logic [31:0]          r_input_a;
  logic [31:0]          r_input_b;
  logic                 r_a_stb;
  logic                 r_b_stb;
  logic                 r_z_ack;

  logic [31:0]          w_a_arr [NUM_REQ];
  logic [31:0]          w_b_arr [NUM_REQ];
  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_pos;
  logic [IDX_W:0]       w_sum;
  logic [IDX_W-1:0]     w_win;
  logic                 w_found;
  logic                 w_a_done;
  logic                 w_b_done;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = bus.req_a[32*gi +: 32];
    assign w_b_arr[gi] = bus.req_b[32*gi +: 32];
  end

  // Rotate requests so rr_ptr sits at bit 0; the lowest set bit is the winner.
  always_comb begin
    w_found = |bus.req;
    w_req2  = {bus.req, bus.req};
    w_rot   = NUM_REQ'(w_req2 >> r_rr_ptr);
    w_pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pos = IDX_W'(k);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_pos};
    w_win = (w_sum >= c_num) ? IDX_W'(w_sum - c_num) : w_sum[IDX_W-1:0];
  end

  assign w_a_done = !r_a_stb || bus.input_a_ack;
  assign w_b_done = !r_b_stb || bus.input_b_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_win       <= '0;
      r_grant     <= '0;
      r_rsp_valid <= '0;
      r_rsp_z     <= '0;
      r_input_a   <= '0;
      r_input_b   <= '0;
      r_a_stb     <= 1'b0;
      r_b_stb     <= 1'b0;
      r_z_ack     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_input_a <= w_a_arr[w_win];
            r_input_b <= w_b_arr[w_win];
            r_win     <= w_win;
            r_grant   <= c_one << w_win;
            r_a_stb   <= 1'b1;
            r_b_stb   <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          // Each strobe retires on its own ack; either order, or together.
          if (r_a_stb && bus.input_a_ack) r_a_stb <= 1'b0;
          if (r_b_stb && bus.input_b_ack) r_b_stb <= 1'b0;
          if (w_a_done && w_b_done) begin
            r_z_ack <= 1'b1;
            r_state <= S_WAIT_Z;
          end
        end
        S_WAIT_Z: begin
          if (bus.output_z_stb) begin
            r_rsp_z     <= bus.output_z;
            r_z_ack     <= 1'b0;
            r_rsp_valid <= r_grant;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid <= '0;
          r_grant     <= '0;
          r_rr_ptr    <= (r_win == c_last) ? '0 : r_win + 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant        = r_grant;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_z        = r_rsp_z;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.input_a      = r_input_a;
  assign bus.input_a_stb  = r_a_stb;
  assign bus.input_b      = r_input_b;
  assign bus.input_b_stb  = r_b_stb;
  assign bus.output_z_ack = r_z_ack;

endmodule

`default_nettype wire

// File: tb/tb_fpu_add_arbiter.sv
// ============================================================================
// Module  : tb_fpu_add_arbiter
// Brief   : Bench for fpu_add_arbiter with a delay-programmable adder model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_add_arbiter;

  logic clk;
  logic rst;
  fpu_add_arbiter_if #(.NUM_REQ(4)) bus ();

  fpu_add_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] op_a [4];
  logic [31:0] op_b [4];
  logic [3:0]  req_m;
  int          model_ptr;

  // ---------------- floating-point reference (normal numbers only) --------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    m = {1'b0, d[51:29]};
    if (d[28] && ((d[27:0] != 28'd0) || d[29])) m = m + 24'd1;
    if (m[23]) begin
      m = 24'd0;
      e = e + 1;
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(120, 134));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  // First requesting index at or above p, wrapping around four requesters.
  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    int n;
    r = -1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        r = i;
        n++;
      end
    end
    return (n == 1) ? r : -1;
  endfunction

  // ---------------- behavioural adder with programmable delays ------------
  int          a_dly = 0, b_dly = 0, z_dly = 0;
  int          a_cnt, b_cnt, z_cnt;
  logic        a_have, b_have;
  logic [31:0] cap_a, cap_b;

  assign bus.input_a_ack  = bus.input_a_stb && !a_have && (a_cnt >= a_dly);
  assign bus.input_b_ack  = bus.input_b_stb && !b_have && (b_cnt >= b_dly);
  assign bus.output_z_stb = a_have && b_have && (z_cnt >= z_dly);
  always_comb bus.output_z = fp_add(cap_a, cap_b);

  always @(posedge clk) begin
    if (rst) begin
      a_have <= 1'b0; b_have <= 1'b0;
      a_cnt  <= 0;    b_cnt  <= 0;    z_cnt <= 0;
      cap_a  <= 32'h0; cap_b <= 32'h0;
    end else begin
      if (bus.input_a_ack) begin
        a_have <= 1'b1; cap_a <= bus.input_a; a_cnt <= 0;
      end else if (bus.input_a_stb && !a_have) begin
        a_cnt <= a_cnt + 1;
      end
      if (bus.input_b_ack) begin
        b_have <= 1'b1; cap_b <= bus.input_b; b_cnt <= 0;
      end else if (bus.input_b_stb && !b_have) begin
        b_cnt <= b_cnt + 1;
      end
      if (bus.output_z_stb && bus.output_z_ack) begin
        a_have <= 1'b0; b_have <= 1'b0; z_cnt <= 0;
      end else if (a_have && b_have) begin
        z_cnt <= z_cnt + 1;
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic drive();
    bus.req = req_m;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[32*i +: 32] = op_a[i];
      bus.req_b[32*i +: 32] = op_b[i];
    end
  endtask

  task automatic wait_rsp(input int budget, output bit got, output int idx,
                          output logic [31:0] z, output logic [3:0] g, output int lat);
    got = 1'b0; idx = -1; z = 32'h0; g = 4'h0; lat = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid != 4'h0) begin
        got = 1'b1;
        idx = oh_idx(bus.rsp_valid);
        z   = bus.rsp_z;
        g   = bus.grant;
        break;
      end
    end
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    req_m = 4'h0;
    for (int i = 0; i < 4; i++) begin op_a[i] = 32'h0; op_b[i] = 32'h0; end
    drive();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.grant, bus.rsp_valid, bus.busy} !== 9'h0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %h expected 0", {bus.grant, bus.rsp_valid, bus.busy});
    end
    n_vec++;
    if ({bus.rsp_z, bus.input_a, bus.input_b} !== 96'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", {bus.rsp_z, bus.input_a, bus.input_b});
    end
    n_vec++;
    if ({bus.input_a_stb, bus.input_b_stb, bus.output_z_ack} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_hs: got %b expected 000",
               {bus.input_a_stb, bus.input_b_stb, bus.output_z_ack});
    end
    rst = 1'b0;
    model_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit got; int idx; logic [31:0] z; logic [3:0] g; int lat;
    op_a[0] = 32'h433E95C3;
    op_b[0] = 32'h40E80000;
    req_m = 4'b0001;
    drive();
    wait_rsp(30, got, idx, z, g, lat);
    n_vec++;
    if (!got || idx != 0) begin
      n_err++; $display("FAIL single_idx: got %0d (seen %0b) expected 0", idx, got);
    end
    n_vec++;
    if (z !== 32'h4345D5C3) begin
      n_err++; $display("FAIL single_z: got %h expected 4345d5c3", z);
    end
    n_vec++;
    if (lat + 1 != 4) begin
      n_err++; $display("FAIL single_latency: got %0d expected 4", lat + 1);
    end
    n_vec++;
    if (g !== 4'b0001) begin
      n_err++; $display("FAIL single_grant: got %b expected 0001", g);
    end
    model_ptr = 1;
    req_m = 4'h0;
    drive();
    @(negedge clk);
    n_vec++;
    if ({bus.rsp_valid, bus.busy, bus.grant} !== 9'h0) begin
      n_err++; $display("FAIL single_idle: got %h expected 0", {bus.rsp_valid, bus.busy, bus.grant});
    end
  endtask

  task automatic test_reset_midop();
    bit seen; int pulses; int busy_seen;
    z_dly = 5;
    op_a[1] = rand_fp(); op_b[1] = rand_fp();
    req_m = 4'b0010;
    drive();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.output_z_ack) begin seen = 1'b1; break; end
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL midop_reach_wait_z: got 0 expected 1");
    end
    rst = 1'b1;
    req_m = 4'h0;
    drive();
    #1;
    n_vec++;
    if ({bus.grant, bus.rsp_valid, bus.busy, bus.input_a_stb, bus.input_b_stb,
         bus.output_z_ack, bus.rsp_z, bus.input_a, bus.input_b} !== 108'h0) begin
      n_err++;
      $display("FAIL midop_reset_outputs: got %h/%b/%b expected all 0",
               {bus.grant, bus.rsp_valid}, bus.busy, bus.output_z_ack);
    end
    @(negedge clk);
    rst = 1'b0;
    z_dly = 0;
    model_ptr = 0;
    pulses = 0; busy_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != 4'h0) pulses++;
      if (bus.busy) busy_seen++;
    end
    n_vec++;
    if (pulses != 0 || busy_seen != 0) begin
      n_err++; $display("FAIL midop_after_release: got pulses=%0d busy=%0d expected 0/0", pulses, busy_seen);
    end
  endtask

  task automatic test_all_four();
    bit got; int idx; logic [31:0] z; logic [3:0] g; int lat; int e;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    req_m = 4'b1111;
    for (int i = 0; i < 4; i++) begin op_a[i] = rand_fp(); op_b[i] = rand_fp(); end
    drive();
    for (int k = 0; k < 5; k++) begin
      e = exp_order[k];
      wait_rsp(40, got, idx, z, g, lat);
      n_vec++;
      if (!got || idx != e) begin
        n_err++; $display("FAIL rr4_order[%0d]: got %0d expected %0d", k, idx, e);
      end
      n_vec++;
      if (z !== fp_add(op_a[e], op_b[e])) begin
        n_err++; $display("FAIL rr4_z[%0d]: got %h expected %h", k, z, fp_add(op_a[e], op_b[e]));
      end
      model_ptr = (e + 1) % 4;
      op_a[e] = rand_fp(); op_b[e] = rand_fp();
      if (k == 4) req_m = 4'h0;
      drive();
      @(negedge clk);
      n_vec++;
      if ({bus.rsp_valid, bus.busy, bus.grant} !== 9'h0) begin
        n_err++; $display("FAIL rr4_idle[%0d]: got %h expected 0", k, {bus.rsp_valid, bus.busy, bus.grant});
      end
    end
  endtask

  task automatic test_stb_order();
    int dly_a [2] = '{3, 2};
    int dly_b [2] = '{0, 2};
    int a_hi, b_hi, pulses; logic [31:0] z;
    for (int k = 0; k < 2; k++) begin
      a_dly = dly_a[k]; b_dly = dly_b[k]; z_dly = 0;
      op_a[2] = rand_fp(); op_b[2] = rand_fp();
      req_m = 4'b0100;
      drive();
      a_hi = 0; b_hi = 0; pulses = 0; z = 32'h0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.input_a_stb) a_hi++;
        if (bus.input_b_stb) b_hi++;
        if (bus.rsp_valid != 4'h0) begin
          pulses++;
          z = bus.rsp_z;
          req_m = 4'h0;
          drive();
        end
      end
      n_vec++;
      if (a_hi != dly_a[k] + 1 || b_hi != dly_b[k] + 1) begin
        n_err++; $display("FAIL stb_len[%0d]: got a=%0d b=%0d expected a=%0d b=%0d",
                          k, a_hi, b_hi, dly_a[k] + 1, dly_b[k] + 1);
      end
      n_vec++;
      if (pulses != 1 || z !== fp_add(op_a[2], op_b[2])) begin
        n_err++; $display("FAIL stb_rsp[%0d]: got pulses=%0d z=%h expected 1 z=%h",
                          k, pulses, z, fp_add(op_a[2], op_b[2]));
      end
      model_ptr = 3;
    end
    a_dly = 0; b_dly = 0;
  endtask

  task automatic test_wrap();
    logic [3:0] masks [3] = '{4'b0010, 4'b0011, 4'b0010};
    int         exps  [3] = '{1, 0, 1};
    bit got; int idx; logic [31:0] z; logic [3:0] g; int lat;
    for (int k = 0; k < 3; k++) begin
      req_m = masks[k];
      for (int i = 0; i < 4; i++) begin op_a[i] = rand_fp(); op_b[i] = rand_fp(); end
      drive();
      wait_rsp(30, got, idx, z, g, lat);
      n_vec++;
      if (!got || idx != exps[k] || z !== fp_add(op_a[exps[k]], op_b[exps[k]])) begin
        n_err++; $display("FAIL wrap[%0d]: got idx=%0d z=%h expected idx=%0d z=%h",
                          k, idx, z, exps[k], fp_add(op_a[exps[k]], op_b[exps[k]]));
      end
      model_ptr = (exps[k] + 1) % 4;
      req_m = 4'h0;
      drive();
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bit got; int idx; logic [31:0] z; logic [3:0] g; int lat; int pulses;
    req_m = 4'b1000;
    op_a[3] = 32'h3F800000; op_b[3] = 32'h3F800000;
    drive();
    for (int k = 0; k < 2; k++) begin
      wait_rsp(30, got, idx, z, g, lat);
      n_vec++;
      if (!got || idx != 3 || z !== 32'h40000000) begin
        n_err++; $display("FAIL b2b[%0d]: got idx=%0d z=%h expected idx=3 z=40000000", k, idx, z);
      end
      op_a[3] = 32'h3F800000; op_b[3] = 32'h3F800000;
      if (k == 1) req_m = 4'h0;
      drive();
    end
    model_ptr = 0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != 4'h0) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++; $display("FAIL b2b_extra_pulse: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_random();
    bit got; int idx; logic [31:0] z; logic [3:0] g; int lat; int e;
    req_m = 4'($urandom_range(1, 15));
    for (int i = 0; i < 4; i++) begin op_a[i] = rand_fp(); op_b[i] = rand_fp(); end
    drive();
    for (int n = 0; n < 40; n++) begin
      a_dly = $urandom_range(0, 5); b_dly = $urandom_range(0, 5); z_dly = $urandom_range(0, 5);
      e = pick(req_m, model_ptr);
      wait_rsp(60, got, idx, z, g, lat);
      n_vec++;
      if (!got || idx != e || g !== (4'b0001 << e) || z !== fp_add(op_a[e], op_b[e])) begin
        n_err++; $display("FAIL rand[%0d]: got idx=%0d grant=%b z=%h expected idx=%0d z=%h",
                          n, idx, g, z, e, fp_add(op_a[e], op_b[e]));
      end
      model_ptr = (e + 1) % 4;
      if ($urandom_range(0, 1) == 0) req_m[e] = 1'b0;
      else begin op_a[e] = rand_fp(); op_b[e] = rand_fp(); end
      for (int i = 0; i < 4; i++) begin
        if (i != e && !req_m[i] && $urandom_range(0, 2) == 0) begin
          req_m[i] = 1'b1; op_a[i] = rand_fp(); op_b[i] = rand_fp();
        end
      end
      if (req_m == 4'h0) begin
        req_m[e] = 1'b1; op_a[e] = rand_fp(); op_b[e] = rand_fp();
      end
      drive();
      @(negedge clk);
      n_vec++;
      if ({bus.rsp_valid, bus.busy, bus.grant} !== 9'h0) begin
        n_err++; $display("FAIL rand_idle[%0d]: got %h expected 0", n, {bus.rsp_valid, bus.busy, bus.grant});
      end
    end
    req_m = 4'h0;
    drive();
    a_dly = 0; b_dly = 0; z_dly = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_reset_midop();
    test_all_four();
    test_stb_order();
    test_wrap();
    test_back_to_back();
    test_random();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
